// File: rtl/rr_stream_mux.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rr_stream_mux : N-input valid/ready stream mux with burst-locked arbitration
// Revision      : 1.0
// ----------------------------------------------------------------------------
module rr_stream_mux #(
  parameter int DATA_WIDTH  = 32,
  parameter int N_INPUTS    = 4,
  parameter int ROUND_ROBIN = 1,
  localparam int SEL_W      = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [N_INPUTS*DATA_WIDTH-1:0] data_i,
  input  logic [N_INPUTS-1:0]            valid_i,
  input  logic [N_INPUTS-1:0]            last_i,
  output logic [N_INPUTS-1:0]            ready_o,
  output logic [DATA_WIDTH-1:0]          data_o,
  output logic                           valid_o,
  output logic                           last_o,
  output logic [SEL_W-1:0]               grant_o,
  input  logic                           ready_i
);

  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_valid;
  logic                  r_last;
  logic [SEL_W-1:0]      r_grant;
  logic [SEL_W-1:0]      r_ptr;
  logic                  r_locked;
  logic [SEL_W-1:0]      r_lock_idx;

  logic [SEL_W-1:0]      w_sel;
  logic [SEL_W-1:0]      w_ptr_nxt;
  logic                  w_any;
  logic                  w_load_en;
  logic                  w_xfer;
  int                    w_idx;

  // A held lock overrides arbitration entirely, even when the locked channel is idle.
  always_comb begin
    w_sel = '0;
    w_any = 1'b0;
    w_idx = 0;
    if (r_locked) begin
      w_sel = r_lock_idx;
      w_any = valid_i[r_lock_idx];
    end else if (ROUND_ROBIN != 0) begin
      for (int i = 0; i < N_INPUTS; i++) begin
        w_idx = int'(r_ptr) + i;
        if (w_idx >= N_INPUTS) w_idx = w_idx - N_INPUTS;
        if (!w_any && valid_i[w_idx]) begin
          w_any = 1'b1;
          w_sel = SEL_W'(w_idx);
        end
      end
    end else begin
      for (int i = N_INPUTS - 1; i >= 0; i--) begin
        if (valid_i[i]) begin
          w_any = 1'b1;
          w_sel = SEL_W'(i);
        end
      end
    end
  end

  assign w_load_en = !r_valid || ready_i;
  assign w_xfer    = w_load_en && w_any && !rst_i;
  assign w_ptr_nxt = (w_sel == SEL_W'(N_INPUTS - 1)) ? '0 : w_sel + 1'b1;

  generate
    for (genvar k = 0; k < N_INPUTS; k++) begin : g_ready
      assign ready_o[k] = w_xfer && (w_sel == SEL_W'(k));
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_last     <= 1'b0;
      r_grant    <= '0;
      r_ptr      <= '0;
      r_locked   <= 1'b0;
      r_lock_idx <= '0;
    end else if (w_load_en) begin
      if (w_xfer) begin
        r_data  <= data_i[int'(w_sel)*DATA_WIDTH +: DATA_WIDTH];
        r_last  <= last_i[w_sel];
        r_grant <= w_sel;
        r_valid <= 1'b1;
        if (!last_i[w_sel]) begin
          r_locked   <= 1'b1;
          r_lock_idx <= w_sel;
        end else begin
          r_locked <= 1'b0;
          if (ROUND_ROBIN != 0) r_ptr <= w_ptr_nxt;
        end
      end else begin
        r_valid <= 1'b0;
      end
    end
  end

  assign data_o  = r_data;
  assign valid_o = r_valid;
  assign last_o  = r_last;
  assign grant_o = r_grant;

endmodule
`default_nettype wire

// File: tb/tb_rr_stream_mux.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_rr_stream_mux : directed bench for rr_stream_mux (RR N=4, fixed N=4, RR N=3)
// Revision         : 1.0
// ----------------------------------------------------------------------------
module tb_rr_stream_mux;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Round-robin, N=4
  logic [127:0] a_data  = '0;
  logic [3:0]   a_valid = '0, a_last = '0, a_ready;
  logic [31:0]  a_dout;
  logic         a_vout, a_lout, a_rdy_in = 1'b1;
  logic [1:0]   a_grant;
  // Fixed priority, N=4
  logic [127:0] b_data  = '0;
  logic [3:0]   b_valid = '0, b_last = '0, b_ready;
  logic [31:0]  b_dout;
  logic         b_vout, b_lout, b_rdy_in = 1'b1;
  logic [1:0]   b_grant;
  // Round-robin, N=3
  logic [95:0]  c_data  = '0;
  logic [2:0]   c_valid = '0, c_last = '0, c_ready;
  logic [31:0]  c_dout;
  logic         c_vout, c_lout, c_rdy_in = 1'b1;
  logic [1:0]   c_grant;

  rr_stream_mux #(.DATA_WIDTH(32), .N_INPUTS(4), .ROUND_ROBIN(1)) u_rr4 (
    .clk_i(clk), .rst_i(rst), .data_i(a_data), .valid_i(a_valid), .last_i(a_last),
    .ready_o(a_ready), .data_o(a_dout), .valid_o(a_vout), .last_o(a_lout),
    .grant_o(a_grant), .ready_i(a_rdy_in));

  rr_stream_mux #(.DATA_WIDTH(32), .N_INPUTS(4), .ROUND_ROBIN(0)) u_fp4 (
    .clk_i(clk), .rst_i(rst), .data_i(b_data), .valid_i(b_valid), .last_i(b_last),
    .ready_o(b_ready), .data_o(b_dout), .valid_o(b_vout), .last_o(b_lout),
    .grant_o(b_grant), .ready_i(b_rdy_in));

  rr_stream_mux #(.DATA_WIDTH(32), .N_INPUTS(3), .ROUND_ROBIN(1)) u_rr3 (
    .clk_i(clk), .rst_i(rst), .data_i(c_data), .valid_i(c_valid), .last_i(c_last),
    .ready_o(c_ready), .data_o(c_dout), .valid_o(c_vout), .last_o(c_lout),
    .grant_o(c_grant), .ready_i(c_rdy_in));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a_valid = 4'b0001; a_last = 4'b1111;
    #1;
    checks++;
    if (a_ready !== 4'b0000) begin
      errors++; $display("FAIL reset_ready: got %b expected 0000", a_ready);
    end
    step(); step();
    a_valid = '0;
    rst = 1'b0;
    #1;
    checks++;
    if (a_vout !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", a_vout); end
    checks++;
    if (a_dout !== 32'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", a_dout); end
    checks++;
    if (a_lout !== 1'b0) begin errors++; $display("FAIL reset_last: got %b expected 0", a_lout); end
    checks++;
    if (a_grant !== 2'd0) begin errors++; $display("FAIL reset_grant: got %0d expected 0", a_grant); end
  endtask

  task automatic test_single();
    a_data[2*32 +: 32] = 32'hA5A5_0001;
    a_last  = 4'b1111;
    a_valid = 4'b0100;
    #1;
    checks++;
    if (a_ready !== 4'b0100) begin errors++; $display("FAIL single_ready: got %b expected 0100", a_ready); end
    step();
    a_valid = '0;
    checks++;
    if ({a_vout, a_lout, a_grant, a_dout} !== {1'b1, 1'b1, 2'd2, 32'hA5A5_0001}) begin
      errors++;
      $display("FAIL single_beat: got v=%b l=%b g=%0d d=%h expected v=1 l=1 g=2 d=a5a50001",
               a_vout, a_lout, a_grant, a_dout);
    end
    step();
    checks++;
    if (a_vout !== 1'b0) begin errors++; $display("FAIL single_drain: got %b expected 0", a_vout); end
  endtask

  task automatic test_rr_fairness();
    int cnt [4];
    for (int k = 0; k < 4; k++) cnt[k] = 0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    a_data  = {32'd3, 32'd2, 32'd1, 32'd0};
    a_last  = 4'b1111;
    a_valid = 4'b1111;
    for (int i = 0; i < 100; i++) begin
      step();
      cnt[a_grant]++;
      checks++;
      if ({a_vout, a_grant, a_dout} !== {1'b1, 2'(i % 4), 32'(i % 4)}) begin
        errors++;
        $display("FAIL rr_seq[%0d]: got v=%b g=%0d d=%0d expected v=1 g=%0d d=%0d",
                 i, a_vout, a_grant, a_dout, i % 4, i % 4);
      end
    end
    a_valid = '0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (cnt[k] !== 25) begin errors++; $display("FAIL rr_count[%0d]: got %0d expected 25", k, cnt[k]); end
    end
    step();
  endtask

  task automatic test_fixed_priority();
    b_last  = 4'b1111;
    b_valid = 4'b1010;
    #1;
    checks++;
    if (b_ready !== 4'b0010) begin errors++; $display("FAIL fp_ready: got %b expected 0010", b_ready); end
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if ({b_vout, b_grant} !== {1'b1, 2'd1}) begin
        errors++; $display("FAIL fp_grant[%0d]: got v=%b g=%0d expected v=1 g=1", i, b_vout, b_grant);
      end
    end
    b_valid = 4'b1000;
    step();
    checks++;
    if ({b_vout, b_grant} !== {1'b1, 2'd3}) begin
      errors++; $display("FAIL fp_low_release: got v=%b g=%0d expected v=1 g=3", b_vout, b_grant);
    end
    b_valid = '0;
    step();
  endtask

  task automatic test_burst_lock();
    a_data  = {32'd0, 32'd0, 32'h1111_0001, 32'h0000_0001};
    a_valid = 4'b0011;
    a_last  = 4'b0010;
    #1;
    checks++;
    if (a_ready !== 4'b0001) begin errors++; $display("FAIL lock_ready_b1: got %b expected 0001", a_ready); end
    step();
    checks++;
    if ({a_grant, a_lout, a_dout} !== {2'd0, 1'b0, 32'h0000_0001}) begin
      errors++; $display("FAIL lock_beat1: got g=%0d l=%b d=%h expected g=0 l=0 d=00000001", a_grant, a_lout, a_dout);
    end
    // locked owner goes idle: ch1 must still be stalled
    a_valid = 4'b0010;
    #1;
    checks++;
    if (a_ready !== 4'b0000) begin errors++; $display("FAIL lock_stall_ready: got %b expected 0000", a_ready); end
    step();
    checks++;
    if (a_vout !== 1'b0) begin errors++; $display("FAIL lock_stall_valid: got %b expected 0", a_vout); end
    a_valid = 4'b0011;
    a_data[31:0] = 32'h0000_0002;
    #1;
    checks++;
    if (a_ready !== 4'b0001) begin errors++; $display("FAIL lock_ready_b2: got %b expected 0001", a_ready); end
    step();
    checks++;
    if ({a_vout, a_grant, a_dout} !== {1'b1, 2'd0, 32'h0000_0002}) begin
      errors++; $display("FAIL lock_beat2: got v=%b g=%0d d=%h expected v=1 g=0 d=00000002", a_vout, a_grant, a_dout);
    end
    a_data[31:0] = 32'h0000_0003;
    a_last = 4'b0011;
    #1;
    checks++;
    if (a_ready !== 4'b0001) begin errors++; $display("FAIL lock_ready_b3: got %b expected 0001", a_ready); end
    step();
    checks++;
    if ({a_grant, a_lout, a_dout} !== {2'd0, 1'b1, 32'h0000_0003}) begin
      errors++; $display("FAIL lock_beat3: got g=%0d l=%b d=%h expected g=0 l=1 d=00000003", a_grant, a_lout, a_dout);
    end
    a_valid = 4'b0010;
    step();
    checks++;
    if ({a_vout, a_grant, a_dout} !== {1'b1, 2'd1, 32'h1111_0001}) begin
      errors++; $display("FAIL lock_next_ch: got v=%b g=%0d d=%h expected v=1 g=1 d=11110001", a_vout, a_grant, a_dout);
    end
    a_valid = '0;
    step();
  endtask

  task automatic test_backpressure();
    a_last  = 4'b1111;
    a_data[2*32 +: 32] = 32'hBEEF_0001;
    a_valid = 4'b0100;
    step();
    a_rdy_in = 1'b0;
    a_data[2*32 +: 32] = 32'hBEEF_0002;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if ({a_ready, a_vout, a_grant, a_dout} !== {4'b0000, 1'b1, 2'd2, 32'hBEEF_0001}) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got r=%b v=%b g=%0d d=%h expected r=0000 v=1 g=2 d=beef0001",
                 i, a_ready, a_vout, a_grant, a_dout);
      end
      step();
    end
    a_rdy_in = 1'b1;
    #1;
    checks++;
    if (a_ready !== 4'b0100) begin errors++; $display("FAIL bp_release_ready: got %b expected 0100", a_ready); end
    step();
    a_valid = '0;
    checks++;
    if ({a_vout, a_dout} !== {1'b1, 32'hBEEF_0002}) begin
      errors++; $display("FAIL bp_no_bubble: got v=%b d=%h expected v=1 d=beef0002", a_vout, a_dout);
    end
    step();
  endtask

  task automatic test_reset_wrap();
    c_data  = {32'hC2C2_0001, 32'hC1C1_0001, 32'hC0C0_0001};
    c_valid = 3'b100;
    c_last  = 3'b000;
    step();
    checks++;
    if ({c_vout, c_grant, c_lout} !== {1'b1, 2'd2, 1'b0}) begin
      errors++; $display("FAIL wrap_burst_b1: got v=%b g=%0d l=%b expected v=1 g=2 l=0", c_vout, c_grant, c_lout);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (c_ready !== 3'b000) begin errors++; $display("FAIL wrap_rst_ready: got %b expected 000", c_ready); end
    step();
    rst = 1'b0;
    checks++;
    if ({c_vout, c_dout, c_grant, c_lout} !== {1'b0, 32'h0, 2'd0, 1'b0}) begin
      errors++; $display("FAIL wrap_rst_out: got v=%b d=%h g=%0d l=%b expected all 0", c_vout, c_dout, c_grant, c_lout);
    end
    c_valid = 3'b101;
    c_last  = 3'b111;
    #1;
    checks++;
    if (c_ready !== 3'b001) begin errors++; $display("FAIL wrap_fresh_ready: got %b expected 001", c_ready); end
    step();
    checks++;
    if ({c_vout, c_grant, c_dout} !== {1'b1, 2'd0, 32'hC0C0_0001}) begin
      errors++; $display("FAIL wrap_first: got v=%b g=%0d d=%h expected v=1 g=0 d=c0c00001", c_vout, c_grant, c_dout);
    end
    step();
    checks++;
    if ({c_vout, c_grant} !== {1'b1, 2'd2}) begin
      errors++; $display("FAIL wrap_ch2: got v=%b g=%0d expected v=1 g=2", c_vout, c_grant);
    end
    c_valid = 3'b111;
    step();
    checks++;
    if (c_grant !== 2'd0) begin errors++; $display("FAIL wrap_ptr0: got g=%0d expected 0", c_grant); end
    step();
    checks++;
    if (c_grant !== 2'd1) begin errors++; $display("FAIL wrap_ptr1: got g=%0d expected 1", c_grant); end
    c_valid = '0;
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_rr_fairness();
    test_fixed_priority();
    test_burst_lock();
    test_backpressure();
    test_reset_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rr_stream_mux.md
Name: rr_stream_mux

Overview:
- Parametrised N-input streaming multiplexer with one registered output stage and valid/ready handshakes on every channel.
- Arbitration between channels is round-robin or fixed-priority, chosen at build time.
- Grant is held for a whole multi-beat burst, delimited by last.
- Used wherever several masters share one downstream datapath (e.g. bus request merge, writeback port sharing). It replaces fixed-select 4:1 muxing where the select must be generated from requests.

Parameters:
- DATA_WIDTH, 32, width of each data channel.
- N_INPUTS, 4, number of input channels; legal range 2..16, need not be a power of two.
- ROUND_ROBIN, 1, 1 = rotating priority; 0 = fixed priority, lowest index wins.
- SEL_W, $clog2(N_INPUTS), width of grant index (localparam; minimum 1).

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  synchronous reset, active-high.
- data_i  input  N_INPUTS*DATA_WIDTH  flattened channel data; channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- valid_i  input  N_INPUTS  per-channel valid.
- last_i  input  N_INPUTS  per-channel end-of-burst marker; single-beat transfers drive 1.
- ready_o  output  N_INPUTS  per-channel ready; at most one bit set.
- data_o  output  DATA_WIDTH  registered output data.
- valid_o  output  1  registered output valid.
- last_o  output  1  registered last of the output beat.
- grant_o  output  SEL_W  index of the channel that supplied the current output beat.
- ready_i  input  1  downstream ready.

Behaviour:
- Reset, synchronous, active-high, one clock and reset only:
  - valid_o=0, data_o=0, last_o=0, grant_o=0.
  - Priority pointer ptr=0, locked=0, lock_idx=0.
  - ready_o=0 while rst_i is high.
- load_en = !valid_o || ready_i. The output register may accept a new beat in the same cycle it is drained.
- Selection (combinational) picks sel among asserted valid_i:
  - locked=1: sel=lock_idx only. Other channels are stalled even if lock_idx is not valid.
  - locked=0, ROUND_ROBIN=1: first asserted valid at index ptr, ptr+1, …, wrapping modulo N_INPUTS.
  - locked=0, ROUND_ROBIN=0: lowest asserted index.
- ready_o[k] = load_en && any-candidate-valid && (sel==k). ready_o may depend combinationally on valid_i; valid_i must never depend on ready_o.
- Transfer on channel k when valid_i[k] && ready_o[k]. At the next edge:
  - data_o<=data_i[k], last_o<=last_i[k], grant_o<=k, valid_o<=1.
  - If last_i[k]=0: locked<=1, lock_idx<=k, ptr unchanged.
  - If last_i[k]=1: locked<=0, and ptr<=(k+1) mod N_INPUTS (round-robin mode only; ptr constant in fixed mode).
- If load_en and no transfer: valid_o<=0; data_o, last_o and grant_o hold their last values.
- Backpressure: while valid_o && !ready_i, data_o, last_o, grant_o and valid_o are held stable and every ready_o is 0.
- Latency is 1 cycle from input handshake to valid_o. Throughput is 1 beat/cycle with ready_i held high.
- No beat is dropped or duplicated. Beats of a burst appear contiguously, with no interleaving of other channels.
- Wrap-around: with a non-power-of-two N_INPUTS, ptr goes from N_INPUTS-1 to 0 and never takes an out-of-range value.
- Simultaneous requests: exactly one grant per cycle; the losing channels keep valid asserted and are served in later cycles.
- Reset mid-burst clears the lock and the output register; the upstream master must restart its burst.
- A locked channel that deasserts valid mid-burst stalls the mux (valid_o drops once drained). The lock persists until that channel presents a beat with last=1.

Test Plan:
- Single channel: N=4, W=32, ready_i=1, channel 2 sends 0xA5A5_0001 with last=1 → one cycle later data_o=0xA5A5_0001, valid_o=1, grant_o=2, last_o=1; the following cycle valid_o=0.
- Round-robin fairness: all 4 valid, single-beat, ready_i=1 continuously → grant_o sequence 0,1,2,3,0,1…; each channel gets exactly 25 of 100 beats.
- Fixed priority (ROUND_ROBIN=0): channels 1 and 3 valid continuously → only channel 1 is granted; channel 3 is granted only after channel 1 deasserts valid.
- Burst lock: channel 0 sends 3 beats with last on beat 3 while channel 1 is valid → output order ch0,ch0,ch0,ch1; ready_o[1]=0 throughout the burst.
- Backpressure: hold ready_i=0 for 5 cycles with valid_o=1 → data_o and grant_o stable and all ready_o=0; on ready_i=1 the next beat loads in the same cycle with no bubble.
- Reset mid-burst plus wrap: N=3, assert rst_i after beat 1 of a ch2 burst → all outputs are 0 next cycle and ptr=0; a fresh request on channels 0 and 2 grants 0 first. Then single-beat ch2 sets ptr to 0, verifying wrap.
